// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control with halt, trap and retire count.
// Latency: branch 3, ALU/jump/upper/store 4, load 5 cycles with zero-wait memory; strobes are registered.
// Backpressure: mem_req holds with stable mem_we/mem_sel until mem_ack; optional MC_SEQ_TIMEOUT_EN traps after 16 idle cycles.
module multicycle_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt_req,
  input  logic [6:0]  opcode,
  input  logic        br_taken,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic        ru_wr,
  output logic [2:0]  state,
  output logic        trap,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t      cur_state;
  state_t      nxt_state;
  state_t      boundary_state;
  logic [6:0]  op_q;
  logic        ir_wr_q;
  logic        pc_wr_q;
  logic        ru_wr_q;
  logic        trap_q;
  logic [15:0] retired_q;
  logic        ir_wr_nxt;
  logic        pc_wr_nxt;
  logic        ru_wr_nxt;
  logic        trap_set;
  logic        timeout;

  // The branch decision only steers the external PC mux; it never alters sequencing here.
  logic unused_br_taken;
  assign unused_br_taken = br_taken;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_JALR, OP_BRANCH,
      OP_STORE, OP_JAL, OP_LUI, OP_AUIPC: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

`ifdef MC_SEQ_TIMEOUT_EN
  logic [3:0] wait_cnt;

  // The 16th consecutive un-acked request cycle is a fatal memory timeout.
  assign timeout = ((cur_state == S_FETCH) || (cur_state == S_MEM)) &&
                   !mem_ack && (wait_cnt == 4'hF);

  // Wait counter: cleared on entry to a request state, counts cycles without ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
    end else if ((nxt_state != cur_state) &&
                 ((nxt_state == S_FETCH) || (nxt_state == S_MEM))) begin
      wait_cnt <= 4'd0;
    end else if (((cur_state == S_FETCH) || (cur_state == S_MEM)) && !mem_ack) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end
`else
  // Without the timeout option a request waits for its ack forever.
  assign timeout = 1'b0;
`endif

  // Instruction boundary: a pending halt request diverts the return to FETCH into HALT.
  assign boundary_state = halt_req ? S_HALT : S_FETCH;

  // Next-state and next-cycle strobe decode; strobes are registered so outputs depend on flops only.
  always_comb begin
    nxt_state = cur_state;
    ir_wr_nxt = 1'b0;
    pc_wr_nxt = 1'b0;
    ru_wr_nxt = 1'b0;
    trap_set  = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (start) nxt_state = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) begin
          nxt_state = S_DECODE;
          ir_wr_nxt = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_legal(opcode)) begin
          nxt_state = S_EXEC;
          // Branches update the PC during EXEC whatever the branch outcome.
          pc_wr_nxt = (opcode == OP_BRANCH);
        end else begin
          nxt_state = S_TRAP;
          trap_set  = 1'b1;
        end
      end
      S_EXEC: begin
        if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
          nxt_state = S_MEM;
        end else if (op_q == OP_BRANCH) begin
          nxt_state = boundary_state;
        end else begin
          nxt_state = S_WB;
          pc_wr_nxt = 1'b1;
          ru_wr_nxt = 1'b1;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          if (op_q == OP_STORE) begin
            nxt_state = boundary_state;
            pc_wr_nxt = 1'b1;
          end else begin
            nxt_state = S_WB;
            pc_wr_nxt = 1'b1;
            ru_wr_nxt = 1'b1;
          end
        end
      end
      S_WB: begin
        nxt_state = boundary_state;
      end
      S_HALT: begin
        if (start && !halt_req) nxt_state = S_FETCH;
      end
      S_TRAP: begin
        nxt_state = S_TRAP;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
    if (timeout) begin
      nxt_state = S_TRAP;
      trap_set  = 1'b1;
      ir_wr_nxt = 1'b0;
      pc_wr_nxt = 1'b0;
      ru_wr_nxt = 1'b0;
    end
  end

  // State register plus latched opcode so EXEC/MEM decisions stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_IDLE;
      op_q      <= 7'd0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_DECODE) op_q <= opcode;
    end
  end

  // Registered one-cycle strobes, sticky trap flag and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_wr_q   <= 1'b0;
      pc_wr_q   <= 1'b0;
      ru_wr_q   <= 1'b0;
      trap_q    <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      ir_wr_q <= ir_wr_nxt;
      pc_wr_q <= pc_wr_nxt;
      ru_wr_q <= ru_wr_nxt;
      trap_q  <= trap_q | trap_set;
      // Counts alongside the pc_wr pulse it accompanies; wraps naturally at 16 bits.
      if (pc_wr_nxt) retired_q <= retired_q + 16'd1;
    end
  end

  assign mem_req = (cur_state == S_FETCH) || (cur_state == S_MEM);
  assign mem_sel = (cur_state == S_MEM);
  assign mem_we  = (cur_state == S_MEM) && (op_q == OP_STORE);
  assign ir_wr   = ir_wr_q;
  assign pc_wr   = pc_wr_q;
  assign ru_wr   = ru_wr_q;
  assign state   = cur_state;
  assign trap    = trap_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: directed scenarios plus randomized instruction stream.
// Expected per-cycle traces are generated from instruction-class rules, not from the RTL structure.
// MC_SEQ_TIMEOUT_EN selects which timeout behaviour is expected.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic [6:0]  opcode;
  logic        br_taken;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic        mem_sel;
  logic        ir_wr;
  logic        pc_wr;
  logic        ru_wr;
  logic [2:0]  state;
  logic        trap;
  logic [15:0] retired;

  multicycle_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .halt_req (halt_req),
    .opcode   (opcode),
    .br_taken (br_taken),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_sel  (mem_sel),
    .ir_wr    (ir_wr),
    .pc_wr    (pc_wr),
    .ru_wr    (ru_wr),
    .state    (state),
    .trap     (trap),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1100011,
                                7'b0100011, 7'b1101111, 7'b0110111, 7'b0010111};

  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  // Model state: expected retire count, store pc_wr still to appear, and where the sequencer rests.
  logic [15:0] exp_ret;
  logic        pend_pc;
  int          rest;   // 0 = IDLE, 1 = about to fetch, 6 = HALT

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One cycle: check outputs for this cycle, then drive the inputs sampled at its closing edge.
  task automatic step(input logic [2:0] es, input logic ewe, input logic eir, input logic epc,
                      input logic eru, input logic etrap, input logic ack, input logic st,
                      input logic hlt);
    @(negedge clk);
    if (epc) exp_ret = exp_ret + 16'd1;
    chk("state",   {13'd0, state},  {13'd0, es});
    chk("mem_req", {15'd0, mem_req}, {15'd0, (es == 3'd1) || (es == 3'd4)});
    chk("mem_sel", {15'd0, mem_sel}, {15'd0, es == 3'd4});
    chk("mem_we",  {15'd0, mem_we},  {15'd0, ewe});
    chk("ir_wr",   {15'd0, ir_wr},   {15'd0, eir});
    chk("pc_wr",   {15'd0, pc_wr},   {15'd0, epc});
    chk("ru_wr",   {15'd0, ru_wr},   {15'd0, eru});
    chk("trap",    {15'd0, trap},    {15'd0, etrap});
    chk("retired", retired, exp_ret);
    mem_ack  = ack;
    start    = st;
    halt_req = hlt;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; mem_ack = 1'b0; br_taken = 1'b0; opcode = 7'd0;
    #1;
    chk("rst_state",   {13'd0, state},   16'd0);
    chk("rst_mem_req", {15'd0, mem_req}, 16'd0);
    chk("rst_strobes", {13'd0, ir_wr, pc_wr, ru_wr}, 16'd0);
    chk("rst_trap",    {15'd0, trap},    16'd0);
    chk("rst_retired", retired, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ret = 16'd0; pend_pc = 1'b0; rest = 0;
  endtask

  // Trace of one legal instruction: fw/mw extra wait cycles before the fetch/memory ack.
  task automatic run_instr(input logic [6:0] op, input logic br, input int fw, input int mw,
                           input logic hlt);
    logic is_br, is_ld, is_st;
    is_br = (op == OP_BRANCH);
    is_ld = (op == OP_LOAD);
    is_st = (op == OP_STORE);
    opcode = op; br_taken = br;
    if (rest == 0) begin
      step(3'd0, 0, 0, 0, 0, 0, 0, 1, 0);
    end else if (rest == 6) begin
      step(3'd6, 0, 0, pend_pc, 0, 0, 0, 1, 1);   // start with halt_req still high: hold
      pend_pc = 1'b0;
      step(3'd6, 0, 0, 0, 0, 0, 0, 1, 0);
    end
    for (int i = 0; i <= fw; i++) begin
      step(3'd1, 0, 0, (i == 0) ? pend_pc : 1'b0, 0, 0, i == fw, 0, 0);
      pend_pc = 1'b0;
    end
    step(3'd2, 0, 1, 0, 0, 0, 0, 0, 0);
    step(3'd3, 0, 0, is_br, 0, 0, 0, 0, hlt);
    if (is_ld || is_st) begin
      for (int i = 0; i <= mw; i++) step(3'd4, is_st, 0, 0, 0, 0, i == mw, 0, hlt);
      if (is_st) pend_pc = 1'b1;
    end
    if (!is_br && !is_st) step(3'd5, 0, 0, 1, 1, 0, 0, 0, hlt);
    rest = hlt ? 6 : 1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; mem_ack = 1'b0; br_taken = 1'b0; opcode = 7'd0;
    exp_ret = 16'd0; pend_pc = 1'b0; rest = 0;

    // Reset state, then R-type with zero-wait memory: 1,2,3,5,1.
    do_reset();
    run_instr(OP_R, 0, 0, 0, 0);
    // Load with three-cycle memory stall, store, then branches not-taken and taken.
    run_instr(OP_LOAD, 0, 0, 3, 0);
    run_instr(OP_STORE, 0, 0, 0, 0);
    run_instr(OP_BRANCH, 0, 0, 0, 0);
    run_instr(OP_BRANCH, 1, 0, 0, 0);
    // Halt requested from EXEC, then resume from HALT.
    run_instr(OP_R, 0, 1, 0, 1);
    run_instr(OP_STORE, 0, 0, 2, 1);
    run_instr(OP_BRANCH, 1, 0, 0, 0);

    // Retire counter wrap from a preloaded value.
    do_reset();
    step(3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    force dut.retired_q = 16'hFFFE;
    exp_ret = 16'hFFFE;
    step(3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    release dut.retired_q;
    run_instr(OP_BRANCH, 0, 0, 0, 0);
    run_instr(OP_BRANCH, 1, 0, 0, 0);
    run_instr(OP_R, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a fetch request.
    do_reset();
    opcode = OP_R;
    step(3'd0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(3'd1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreq_state",   {13'd0, state},   16'd0);
    chk("midreq_mem_req", {15'd0, mem_req}, 16'd0);
    do_reset();

    // Illegal opcode: TRAP is absorbing regardless of start, cleared by reset.
    opcode = 7'b0000000;
    step(3'd0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(3'd1, 0, 0, 0, 0, 0, 1, 0, 0);
    step(3'd2, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(3'd7, 0, 0, 0, 0, 1, 1'b1, i[0], 0);
    do_reset();

    // Randomized legal instruction stream with random stalls and halts.
    for (int n = 0; n < 40; n++) begin
      run_instr(legal_ops[$urandom_range(8, 0)], 1'($urandom_range(1, 0)),
                $urandom_range(3, 0), $urandom_range(3, 0), ($urandom_range(4, 0) == 0));
    end

    // Memory ack withheld in FETCH.
    do_reset();
    opcode = OP_R;
    step(3'd0, 0, 0, 0, 0, 0, 0, 1, 0);
`ifdef MC_SEQ_TIMEOUT_EN
    for (int i = 0; i < 16; i++) step(3'd1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(3'd7, 0, 0, 0, 0, 1, 0, 0, 0);
`else
    for (int i = 0; i < 100; i++) step(3'd1, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
